// File: rtl/dht_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : dht_display_scan
// Purpose  : Captures DHT11 humidity/temperature integer bytes, converts each
//            to two BCD digits with a sequential double-dabble and
//            time-multiplexes the four digits onto one digit code with
//            active-low one-hot anodes.
// Ports    : clk          - system clock
//            rst_n        - synchronous reset, active-low
//            hum_in       - humidity byte (percent RH)
//            temp_in      - temperature byte (degrees C)
//            data_valid   - one-cycle strobe qualifying hum_in/temp_in
//            digit_code   - BCD digit or BLANK_CODE for the segment encoder
//            anode        - active-low digit select, [3]=hum tens .. [0]=temp ones
//            busy         - conversion in progress
//            out_of_range - [1]=hum > 99, [0]=temp > 99, latched on commit
// Options  : LEADING_ZERO_BLANK_EN - blank a zero tens digit of in-range bytes
// Revision : 1.0 - initial release
// ============================================================================
module dht_display_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hum_in,
    input  logic [7:0] temp_in,
    input  logic       data_valid,
    output logic [3:0] digit_code,
    output logic [3:0] anode,
    output logic       busy,
    output logic [1:0] out_of_range
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_SHIFT  = 2'd1;
    localparam logic [1:0]  S_COMMIT = 2'd2;
    localparam logic [23:0] c_presc_max = 24'(REFRESH_DIV - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_hum_sr, r_temp_sr;
    logic [11:0] r_hum_acc, r_temp_acc;
    logic        r_pend;
    logic [7:0]  r_pend_hum, r_pend_temp;
    logic [3:0]  r_disp [4];
    logic [1:0]  r_oor;
    logic [23:0] r_presc;
    logic [1:0]  r_idx;
    logic [3:0]  r_code, r_anode;

    // One double-dabble step: correct every nibble >= 5, then shift in a bit.
    function automatic logic [11:0] f_dabble_step(input logic [11:0] acc, input logic b);
        logic [11:0] v;
        v = acc;
        for (int i = 0; i < 3; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                v[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return 12'({v, b});
    endfunction

    // Returns {out_of_range, tens, ones} for a finished accumulator.
    function automatic logic [8:0] f_commit(input logic [11:0] acc);
        logic [3:0] tens;
        if (acc[11:8] != 4'd0) begin
            return {1'b1, BLANK_CODE, BLANK_CODE};
        end
        tens = acc[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        if (tens == 4'd0) begin
            tens = BLANK_CODE;
        end
`endif
        return {1'b0, tens, acc[3:0]};
    endfunction

    logic [8:0] w_hum_commit, w_temp_commit;
    logic [7:0] w_src_hum, w_src_temp;
    logic       w_wrap;
    logic [1:0] w_idx_next;

    assign w_hum_commit  = f_commit(r_hum_acc);
    assign w_temp_commit = f_commit(r_temp_acc);
    // A fresh strobe always wins over the pending buffer: it is the newer data.
    assign w_src_hum  = data_valid ? hum_in  : r_pend_hum;
    assign w_src_temp = data_valid ? temp_in : r_pend_temp;

    // ------------------------------------------------------------------------
    // Conversion FSM. SHIFT spends 8 shifting cycles plus one terminal-count
    // cycle, giving a fixed 10-cycle busy window per conversion.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_hum_sr    <= 8'd0;
            r_temp_sr   <= 8'd0;
            r_hum_acc   <= 12'd0;
            r_temp_acc  <= 12'd0;
            r_pend      <= 1'b0;
            r_pend_hum  <= 8'd0;
            r_pend_temp <= 8'd0;
            r_oor       <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                r_disp[i] <= BLANK_CODE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (data_valid) begin
                        r_hum_sr   <= w_src_hum;
                        r_temp_sr  <= w_src_temp;
                        r_hum_acc  <= 12'd0;
                        r_temp_acc <= 12'd0;
                        r_bit_cnt  <= 4'd8;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (data_valid) begin
                        r_pend      <= 1'b1;
                        r_pend_hum  <= hum_in;
                        r_pend_temp <= temp_in;
                    end
                    if (r_bit_cnt != 4'd0) begin
                        r_hum_acc  <= f_dabble_step(r_hum_acc, r_hum_sr[7]);
                        r_temp_acc <= f_dabble_step(r_temp_acc, r_temp_sr[7]);
                        r_hum_sr   <= {r_hum_sr[6:0], 1'b0};
                        r_temp_sr  <= {r_temp_sr[6:0], 1'b0};
                        r_bit_cnt  <= r_bit_cnt - 4'd1;
                    end else begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_disp[3] <= w_hum_commit[7:4];
                    r_disp[2] <= w_hum_commit[3:0];
                    r_disp[1] <= w_temp_commit[7:4];
                    r_disp[0] <= w_temp_commit[3:0];
                    r_oor     <= {w_hum_commit[8], w_temp_commit[8]};
                    if (data_valid || r_pend) begin
                        r_hum_sr   <= w_src_hum;
                        r_temp_sr  <= w_src_temp;
                        r_hum_acc  <= 12'd0;
                        r_temp_acc <= 12'd0;
                        r_bit_cnt  <= 4'd8;
                        r_pend     <= 1'b0;
                        r_state    <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Digit scan. digit_code and anode are loaded together only on a scan
    // step, so a commit never changes the lit digit mid-step.
    // ------------------------------------------------------------------------
    assign w_wrap     = (r_presc == c_presc_max);
    assign w_idx_next = r_idx - 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= 24'd0;
            r_idx   <= 2'd3;
            r_code  <= BLANK_CODE;
            r_anode <= 4'b0111;
        end else if (w_wrap) begin
            r_presc <= 24'd0;
            r_idx   <= w_idx_next;
            r_anode <= ~(4'b0001 << w_idx_next);
            r_code  <= r_disp[w_idx_next];
        end else begin
            r_presc <= r_presc + 24'd1;
        end
    end

    assign digit_code   = r_code;
    assign anode        = r_anode;
    assign busy         = (r_state != S_IDLE);
    assign out_of_range = r_oor;

endmodule
`default_nettype wire
